// File: rtl/operand_fetch_stage_pkg.sv
// Shared core types for the operand-fetch stage: data word, register index
// and the opaque decoded-control bundle.
`ifndef N_REG
`define N_REG 32
`endif

package operand_fetch_stage_pkg;

  localparam int XLEN          = 32;
  localparam int REG_IDX_W     = $clog2(`N_REG);
  localparam int CTRL_BUNDLE_W = 16;

  typedef logic [XLEN-1:0]          data_t;
  typedef logic [REG_IDX_W-1:0]     reg_t;
  typedef logic [CTRL_BUNDLE_W-1:0] ctrl_t;

  // A producer "hits" a source when it is writing and targets that index.
  function automatic logic reg_hit(input logic wr, input reg_t dst, input reg_t src);
    return wr && (dst == src);
  endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Single-operand source select with hazard detection.
// OPFETCH_FORWARDING_EN selects EX/MEM/WB bypassing; otherwise the stage interlocks.
module operand_fwd_mux
  import operand_fetch_stage_pkg::*;
(
  input  reg_t  rs,
  input  data_t rf_data,
  input  logic  ex_valid,
  input  logic  ex_is_load,
  input  reg_t  ex_rd,
  input  data_t ex_result,
  input  logic  mem_valid,
  input  reg_t  mem_rd,
  input  data_t mem_result,
  input  logic  wb_wen,
  input  reg_t  wb_wnum,
  input  data_t wb_wd,
  output data_t operand,
  output logic  hazard
);

`ifdef OPFETCH_FORWARDING_EN
  // Youngest producer wins; a load in EX has no data yet, so it stalls instead.
  always_comb begin
    operand = rf_data;
    hazard  = 1'b0;
    if (rs == '0) begin
      operand = '0;
    end else if (reg_hit(ex_valid && !ex_is_load, ex_rd, rs)) begin
      operand = ex_result;
    end else if (reg_hit(mem_valid, mem_rd, rs)) begin
      operand = mem_result;
    end else if (reg_hit(wb_wen, wb_wnum, rs)) begin
      operand = wb_wd;
    end
    if (rs != '0) begin
      hazard = reg_hit(ex_valid && ex_is_load, ex_rd, rs);
    end
  end
`else
  logic unused_fwd;

  // Without bypassing, any in-flight writer blocks until it leaves WB.
  always_comb begin
    operand = (rs == '0) ? '0 : rf_data;
    hazard  = 1'b0;
    if (rs != '0) begin
      hazard = reg_hit(ex_valid, ex_rd, rs) ||
               reg_hit(mem_valid, mem_rd, rs) ||
               reg_hit(wb_wen, wb_wnum, rs);
    end
  end

  assign unused_fwd = ^{ex_is_load, ex_result, mem_result, wb_wd};
`endif

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand-fetch stage: register-file read, RAW resolution and the ID/EX register.
// Define OPFETCH_FORWARDING_EN to enable EX/MEM/WB operand bypassing.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int CTRL_W = CTRL_BUNDLE_W,
  parameter int REG_W  = $clog2(`N_REG)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_valid,
  output logic              o_ready,
  input  data_t             i_pc,
  input  logic [REG_W-1:0]  i_rs1,
  input  logic [REG_W-1:0]  i_rs2,
  input  logic [REG_W-1:0]  i_rd,
  input  data_t             i_imm,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic [REG_W-1:0]  o_Rnum1,
  output logic [REG_W-1:0]  o_Rnum2,
  input  data_t             i_Rd1,
  input  data_t             i_Rd2,
  input  logic              i_ex_valid,
  input  logic              i_ex_is_load,
  input  logic [REG_W-1:0]  i_ex_rd,
  input  data_t             i_ex_result,
  input  logic              i_mem_valid,
  input  logic [REG_W-1:0]  i_mem_rd,
  input  data_t             i_mem_result,
  input  logic              i_wb_wen,
  input  logic [REG_W-1:0]  i_wb_wnum,
  input  data_t             i_wb_wd,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output data_t             o_pc,
  output data_t             o_op1,
  output data_t             o_op2,
  output data_t             o_imm,
  output logic [REG_W-1:0]  o_rd,
  output logic [CTRL_W-1:0] o_ctrl
);

  data_t op1;
  data_t op2;
  logic  haz1;
  logic  haz2;
  logic  hazard;
  logic  accept;

  assign o_Rnum1 = i_rs1;
  assign o_Rnum2 = i_rs2;

  operand_fwd_mux u_fwd1 (
    .rs(i_rs1), .rf_data(i_Rd1),
    .ex_valid(i_ex_valid), .ex_is_load(i_ex_is_load), .ex_rd(i_ex_rd), .ex_result(i_ex_result),
    .mem_valid(i_mem_valid), .mem_rd(i_mem_rd), .mem_result(i_mem_result),
    .wb_wen(i_wb_wen), .wb_wnum(i_wb_wnum), .wb_wd(i_wb_wd),
    .operand(op1), .hazard(haz1)
  );

  operand_fwd_mux u_fwd2 (
    .rs(i_rs2), .rf_data(i_Rd2),
    .ex_valid(i_ex_valid), .ex_is_load(i_ex_is_load), .ex_rd(i_ex_rd), .ex_result(i_ex_result),
    .mem_valid(i_mem_valid), .mem_rd(i_mem_rd), .mem_result(i_mem_result),
    .wb_wen(i_wb_wen), .wb_wnum(i_wb_wnum), .wb_wd(i_wb_wd),
    .operand(op2), .hazard(haz2)
  );

  assign hazard  = i_valid && (haz1 || haz2);
  assign o_ready = (!o_valid || i_ready) && !hazard && !i_flush;
  assign accept  = i_valid && o_ready;

  // Flush beats hold; a consume without a refill leaves a bubble.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      o_valid <= 1'b0;
      o_pc    <= '0;
      o_op1   <= '0;
      o_op2   <= '0;
      o_imm   <= '0;
      o_rd    <= '0;
      o_ctrl  <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_pc    <= i_pc;
      o_op1   <= op1;
      o_op2   <= op2;
      o_imm   <= i_imm;
      o_rd    <= i_rd;
      o_ctrl  <= i_ctrl;
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: directed vectors, a behavioural
// reference model and a per-cycle compare process. Honours OPFETCH_FORWARDING_EN.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;

  logic        i_clk;
  logic        i_rstn;
  logic        i_valid;
  logic        o_ready;
  data_t       i_pc;
  reg_t        i_rs1, i_rs2, i_rd;
  data_t       i_imm;
  logic [15:0] i_ctrl;
  reg_t        o_Rnum1, o_Rnum2;
  data_t       i_Rd1, i_Rd2;
  logic        i_ex_valid, i_ex_is_load;
  reg_t        i_ex_rd;
  data_t       i_ex_result;
  logic        i_mem_valid;
  reg_t        i_mem_rd;
  data_t       i_mem_result;
  logic        i_wb_wen;
  reg_t        i_wb_wnum;
  data_t       i_wb_wd;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  data_t       o_pc, o_op1, o_op2, o_imm;
  reg_t        o_rd;
  logic [15:0] o_ctrl;

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 0;

  // Reference view of the ID/EX register.
  bit          m_valid;
  data_t       m_pc, m_op1, m_op2, m_imm;
  reg_t        m_rd;
  logic [15:0] m_ctrl;

  operand_fetch_stage dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_imm(i_imm), .i_ctrl(i_ctrl),
    .o_Rnum1(o_Rnum1), .o_Rnum2(o_Rnum2), .i_Rd1(i_Rd1), .i_Rd2(i_Rd2),
    .i_ex_valid(i_ex_valid), .i_ex_is_load(i_ex_is_load), .i_ex_rd(i_ex_rd), .i_ex_result(i_ex_result),
    .i_mem_valid(i_mem_valid), .i_mem_rd(i_mem_rd), .i_mem_result(i_mem_result),
    .i_wb_wen(i_wb_wen), .i_wb_wnum(i_wb_wnum), .i_wb_wd(i_wb_wd),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_op1(o_op1), .o_op2(o_op2), .o_imm(o_imm), .o_rd(o_rd), .o_ctrl(o_ctrl)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic data_t model_operand(input reg_t rs, input data_t rf);
    if (rs == 0) return '0;
`ifdef OPFETCH_FORWARDING_EN
    if (i_ex_valid && !i_ex_is_load && i_ex_rd == rs) return i_ex_result;
    if (i_mem_valid && i_mem_rd == rs) return i_mem_result;
    if (i_wb_wen && i_wb_wnum == rs) return i_wb_wd;
`endif
    return rf;
  endfunction

  function automatic bit src_blocked(input reg_t rs);
    if (rs == 0) return 1'b0;
`ifdef OPFETCH_FORWARDING_EN
    return i_ex_valid && i_ex_is_load && i_ex_rd == rs;
`else
    return (i_ex_valid && i_ex_rd == rs) || (i_mem_valid && i_mem_rd == rs) ||
           (i_wb_wen && i_wb_wnum == rs);
`endif
  endfunction

  function automatic bit model_ready();
    bit blocked;
    blocked = i_valid && (src_blocked(i_rs1) || src_blocked(i_rs2));
    return (!m_valid || i_ready) && !blocked && !i_flush;
  endfunction

  always @(posedge i_clk) begin
    bit take;
    take = i_valid && model_ready();
    if (!i_rstn) begin
      m_valid = 0; m_pc = '0; m_op1 = '0; m_op2 = '0; m_imm = '0; m_rd = '0; m_ctrl = '0;
    end else if (i_flush) begin
      m_valid = 0;
    end else if (take) begin
      m_valid = 1;
      m_pc    = i_pc;
      m_op1   = model_operand(i_rs1, i_Rd1);
      m_op2   = model_operand(i_rs2, i_Rd2);
      m_imm   = i_imm;
      m_rd    = i_rd;
      m_ctrl  = i_ctrl;
    end else if (m_valid && i_ready) begin
      m_valid = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (check_en) begin
      checkOutput("cmp_ready", 32'(o_ready), 32'(model_ready()));
      checkOutput("cmp_valid", 32'(o_valid), 32'(m_valid));
      checkOutput("cmp_rnum1", 32'(o_Rnum1), 32'(i_rs1));
      checkOutput("cmp_rnum2", 32'(o_Rnum2), 32'(i_rs2));
      if (m_valid) begin
        checkOutput("cmp_pc", o_pc, m_pc);
        checkOutput("cmp_op1", o_op1, m_op1);
        checkOutput("cmp_op2", o_op2, m_op2);
        checkOutput("cmp_imm", o_imm, m_imm);
        checkOutput("cmp_rd", 32'(o_rd), 32'(m_rd));
        checkOutput("cmp_ctrl", 32'(o_ctrl), 32'(m_ctrl));
      end
    end
  end

  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_valid = 0; i_pc = '0; i_rs1 = '0; i_rs2 = '0; i_rd = '0; i_imm = '0; i_ctrl = '0;
    i_Rd1 = '0; i_Rd2 = '0; i_ex_valid = 0; i_ex_is_load = 0; i_ex_rd = '0; i_ex_result = '0;
    i_mem_valid = 0; i_mem_rd = '0; i_mem_result = '0; i_wb_wen = 0; i_wb_wnum = '0;
    i_wb_wd = '0; i_flush = 0; i_ready = 0;
  endtask

  initial begin
    idle();
    i_rstn = 0;
    applyStimulus();
    applyStimulus();
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_pc", o_pc, 32'd0);
    check_en = 1;

    // Reset mid-stream
    i_rstn = 1;
    i_valid = 1; i_pc = 32'h100; i_rs1 = 5'd1; i_rs2 = 5'd2; i_rd = 5'd3; i_imm = 32'h55;
    i_ctrl = 16'h1234; i_Rd1 = 32'h11; i_Rd2 = 32'h22;
    #1 checkOutput("ready_after_reset", 32'(o_ready), 32'd1);
    applyStimulus();
    checkOutput("first_valid", 32'(o_valid), 32'd1);
    checkOutput("first_op1", o_op1, 32'h11);
    checkOutput("first_ctrl", 32'(o_ctrl), 32'h1234);
    i_rstn = 0;
    applyStimulus();
    checkOutput("midreset_valid", 32'(o_valid), 32'd0);
    checkOutput("midreset_op1", o_op1, 32'd0);
    checkOutput("midreset_op2", o_op2, 32'd0);
    checkOutput("midreset_pc", o_pc, 32'd0);
    checkOutput("midreset_imm", o_imm, 32'd0);
    checkOutput("midreset_rd", 32'(o_rd), 32'd0);
    checkOutput("midreset_ctrl", 32'(o_ctrl), 32'd0);
    i_rstn = 1;
    idle();

    // Backpressure then back-to-back refill
    i_valid = 1; i_pc = 32'h104; i_rs1 = 5'd1; i_rs2 = 5'd2; i_rd = 5'd6; i_Rd1 = 32'h33; i_Rd2 = 32'h44;
    i_ready = 1;
    applyStimulus();
    checkOutput("bp_load_pc", o_pc, 32'h104);
    i_pc = 32'h108; i_Rd1 = 32'h55; i_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("bp_ready_low", 32'(o_ready), 32'd0);
      applyStimulus();
      checkOutput("bp_hold_pc", o_pc, 32'h104);
      checkOutput("bp_hold_op1", o_op1, 32'h33);
    end
    i_ready = 1;
    #1 checkOutput("bp_release_ready", 32'(o_ready), 32'd1);
    applyStimulus();
    checkOutput("bp_next_pc", o_pc, 32'h108);
    checkOutput("bp_next_valid", 32'(o_valid), 32'd1);
    idle(); i_ready = 1;
    applyStimulus();
    checkOutput("drain_valid", 32'(o_valid), 32'd0);

    // x0 as a load destination must not stall or forward
    i_valid = 1; i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd0; i_ex_result = 32'd9;
    #1 checkOutput("x0_no_hazard", 32'(o_ready), 32'd1);
    applyStimulus();
    checkOutput("x0_op1", o_op1, 32'd0);
    idle(); i_ready = 1;

    // Flush overrides both a hold and a load-use stall
    i_valid = 1; i_pc = 32'h200; i_rs1 = 5'd8; i_Rd1 = 32'h80;
    applyStimulus();
    i_ready = 0; i_pc = 32'h204; i_rs1 = 5'd3;
    i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd3; i_flush = 1;
    #1 checkOutput("flush_ready", 32'(o_ready), 32'd0);
    applyStimulus();
    checkOutput("flush_valid", 32'(o_valid), 32'd0);
    checkOutput("flush_no_accept_pc", o_pc, 32'h200);
    idle(); i_ready = 1;

`ifdef OPFETCH_FORWARDING_EN
    // EX then MEM forwarding
    i_valid = 1; i_rs1 = 5'd5; i_Rd1 = 32'h11;
    i_ex_valid = 1; i_ex_rd = 5'd5; i_ex_result = 32'hAAAA0000;
    applyStimulus();
    checkOutput("fwd_ex_op1", o_op1, 32'hAAAA0000);
    i_ex_valid = 0; i_mem_valid = 1; i_mem_rd = 5'd5; i_mem_result = 32'h22;
    applyStimulus();
    checkOutput("fwd_mem_op1", o_op1, 32'h22);
    // Priority EX > MEM > WB
    i_rs1 = 5'd0; i_rs2 = 5'd7; i_Rd2 = 32'h99;
    i_ex_valid = 1; i_ex_rd = 5'd7; i_ex_result = 32'd1;
    i_mem_valid = 1; i_mem_rd = 5'd7; i_mem_result = 32'd2;
    i_wb_wen = 1; i_wb_wnum = 5'd7; i_wb_wd = 32'd3;
    applyStimulus();
    checkOutput("prio_op2", o_op2, 32'd1);
    checkOutput("prio_op1_x0", o_op1, 32'd0);
    idle(); i_ready = 1;
    i_valid = 1; i_ex_valid = 1; i_ex_rd = 5'd0; i_ex_result = 32'd9;
    applyStimulus();
    checkOutput("x0_no_fwd", o_op1, 32'd0);
    idle(); i_ready = 1;
    // Load-use stall then MEM supplies the load data
    i_valid = 1; i_pc = 32'h300; i_rs1 = 5'd1; i_rs2 = 5'd3; i_Rd1 = 32'h5; i_Rd2 = 32'h1;
    i_ex_valid = 1; i_ex_is_load = 1; i_ex_rd = 5'd3;
    #1 checkOutput("lu_ready", 32'(o_ready), 32'd0);
    applyStimulus();
    checkOutput("lu_bubble", 32'(o_valid), 32'd0);
    i_ex_valid = 0; i_ex_is_load = 0; i_mem_valid = 1; i_mem_rd = 5'd3; i_mem_result = 32'hDEAD;
    #1 checkOutput("lu_release_ready", 32'(o_ready), 32'd1);
    applyStimulus();
    checkOutput("lu_op2", o_op2, 32'hDEAD);
    checkOutput("lu_pc", o_pc, 32'h300);
`else
    // WB writer interlock, then the register file supplies the new value
    i_valid = 1; i_pc = 32'h400; i_rs1 = 5'd4; i_Rd1 = 32'h10;
    i_wb_wen = 1; i_wb_wnum = 5'd4; i_wb_wd = 32'h77;
    #1 checkOutput("wb_stall_ready", 32'(o_ready), 32'd0);
    applyStimulus();
    checkOutput("wb_stall_valid", 32'(o_valid), 32'd0);
    i_wb_wen = 0; i_Rd1 = 32'h77;
    #1 checkOutput("wb_release_ready", 32'(o_ready), 32'd1);
    applyStimulus();
    checkOutput("wb_rf_op1", o_op1, 32'h77);
    checkOutput("wb_rf_valid", 32'(o_valid), 32'd1);
    // Non-load EX and MEM writers also interlock
    i_rs1 = 5'd0; i_rs2 = 5'd5; i_ex_valid = 1; i_ex_rd = 5'd5;
    #1 checkOutput("nofwd_ex_stall", 32'(o_ready), 32'd0);
    applyStimulus();
    i_ex_valid = 0; i_mem_valid = 1; i_mem_rd = 5'd5;
    #1 checkOutput("nofwd_mem_stall", 32'(o_ready), 32'd0);
    applyStimulus();
`endif

    idle(); i_ready = 1;
    applyStimulus();
    applyStimulus();
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
